// File: rtl/cart_mbc_snoop.sv
// Passive snooper of cartridge mapper writes: shadows MBC1/MBC3/MBC5 bank registers
// from completed CART_WR strobes into 0x0000-0x7FFF and exports the effective banking state.
module cart_mbc_snoop #(
    parameter int unsigned WCNT_W = 16
) (
    input  logic              hclk,
    input  logic              gbreset,
    input  logic [2:0]        mbc_type,
    input  logic [15:0]       CART_A,
    input  logic              CART_WR,
    input  logic [7:0]        CART_DOUT,
    output logic [8:0]        rom_bank,
    output logic [3:0]        ram_bank,
    output logic              ram_en,
    output logic [3:0]        rtc_sel,
    output logic              rtc_mode,
    output logic              mbc1_mode,
    output logic              rtc_latch,
    output logic              bank_chg,
    output logic [WCNT_W-1:0] wr_cnt
);

    localparam logic [2:0] TypeMbc1 = 3'd1;
    localparam logic [2:0] TypeMbc3 = 3'd3;
    localparam logic [2:0] TypeMbc5 = 3'd5;

    typedef enum logic {StIdle, StArmed} latch_e;

    latch_e            latch_q, latch_d;
    logic              wr_q;
    logic [2:0]        type_q, type_d;
    logic [15:12]      a_cap_q, a_cap_d;
    logic [7:0]        d_cap_q, d_cap_d;
    logic [8:0]        rom_bank_q, rom_bank_d;
    logic [3:0]        ram_bank_q, ram_bank_d;
    logic              ram_en_q, ram_en_d;
    logic [3:0]        rtc_sel_q, rtc_sel_d;
    logic              rtc_mode_q, rtc_mode_d;
    logic              mbc1_mode_q, mbc1_mode_d;
    logic [4:0]        b1_q, b1_d;
    logic [1:0]        b2_q, b2_d;
    logic              rtc_latch_d, rtc_latch_q;
    logic              bank_chg_d, bank_chg_q;
    logic [WCNT_W-1:0] wr_cnt_q, wr_cnt_d;

    logic commit;
    logic known;
    logic unused_addr;

    // Only the top nibble of the address selects a mapper register.
    assign unused_addr = ^CART_A[11:0];

    assign commit = !wr_q && CART_WR && !a_cap_q[15];
    assign known  = (type_q == TypeMbc1) || (type_q == TypeMbc3) || (type_q == TypeMbc5);

    always_comb begin
        latch_d     = latch_q;
        type_d      = type_q;
        a_cap_d     = a_cap_q;
        d_cap_d     = d_cap_q;
        rom_bank_d  = rom_bank_q;
        ram_bank_d  = ram_bank_q;
        ram_en_d    = ram_en_q;
        rtc_sel_d   = rtc_sel_q;
        rtc_mode_d  = rtc_mode_q;
        mbc1_mode_d = mbc1_mode_q;
        b1_d        = b1_q;
        b2_d        = b2_q;
        rtc_latch_d = 1'b0;
        bank_chg_d  = 1'b0;
        wr_cnt_d    = wr_cnt_q;

        if (wr_q && !CART_WR) begin
            a_cap_d = CART_A[15:12];
            d_cap_d = CART_DOUT;
        end

        if (type_q != mbc_type) begin
            // Mapper switch: bank state back to power-on, pending commit dropped.
            type_d      = mbc_type;
            latch_d     = StIdle;
            rom_bank_d  = 9'd1;
            ram_bank_d  = 4'd0;
            ram_en_d    = 1'b0;
            rtc_sel_d   = 4'd0;
            rtc_mode_d  = 1'b0;
            mbc1_mode_d = 1'b0;
            b1_d        = 5'd1;
            b2_d        = 2'd0;
        end else if (commit && known) begin
            if (wr_cnt_q != {WCNT_W{1'b1}}) begin
                wr_cnt_d = wr_cnt_q + {{(WCNT_W-1){1'b0}}, 1'b1};
            end
            unique case (type_q)
                TypeMbc1: begin
                    unique case (a_cap_q[14:13])
                        2'b00: ram_en_d = (d_cap_q[3:0] == 4'hA);
                        2'b01: b1_d = (d_cap_q[4:0] == 5'd0) ? 5'd1 : d_cap_q[4:0];
                        2'b10: b2_d = d_cap_q[1:0];
                        2'b11: mbc1_mode_d = d_cap_q[0];
                    endcase
                    rom_bank_d = {2'b00, b2_d, b1_d};
                    ram_bank_d = mbc1_mode_d ? {2'b00, b2_d} : 4'd0;
                end
                TypeMbc3: begin
                    unique case (a_cap_q[14:13])
                        2'b00: ram_en_d = (d_cap_q[3:0] == 4'hA);
                        2'b01: begin
                            rom_bank_d = (d_cap_q[6:0] == 7'd0) ? 9'd1 : {2'b00, d_cap_q[6:0]};
                        end
                        2'b10: begin
                            if (d_cap_q[7:2] == 6'd0) begin
                                ram_bank_d = {2'b00, d_cap_q[1:0]};
                                rtc_mode_d = 1'b0;
                                rtc_sel_d  = 4'd0;
                            end else if (d_cap_q >= 8'h08 && d_cap_q <= 8'h0C) begin
                                rtc_mode_d = 1'b1;
                                rtc_sel_d  = d_cap_q[3:0];
                            end
                        end
                        2'b11: begin
                            if (latch_q == StIdle) begin
                                if (d_cap_q == 8'h00) latch_d = StArmed;
                            end else if (d_cap_q == 8'h01) begin
                                rtc_latch_d = 1'b1;
                                latch_d     = StIdle;
                            end else if (d_cap_q != 8'h00) begin
                                latch_d = StIdle;
                            end
                        end
                    endcase
                end
                default: begin
                    if (a_cap_q[14:13] == 2'b00) begin
                        ram_en_d = (d_cap_q == 8'h0A);
                    end else if (a_cap_q[14:12] == 3'b010) begin
                        rom_bank_d[7:0] = d_cap_q;
                    end else if (a_cap_q[14:12] == 3'b011) begin
                        rom_bank_d[8] = d_cap_q[0];
                    end else if (a_cap_q[14:13] == 2'b10) begin
                        ram_bank_d = d_cap_q[3:0];
                    end
                end
            endcase
            bank_chg_d = ({rom_bank_d, ram_bank_d} != {rom_bank_q, ram_bank_q});
        end
    end

    always_ff @(posedge hclk or posedge gbreset) begin
        if (gbreset) begin
            latch_q     <= StIdle;
            wr_q        <= 1'b1;
            type_q      <= mbc_type;
            a_cap_q     <= 4'd0;
            d_cap_q     <= 8'd0;
            rom_bank_q  <= 9'd1;
            ram_bank_q  <= 4'd0;
            ram_en_q    <= 1'b0;
            rtc_sel_q   <= 4'd0;
            rtc_mode_q  <= 1'b0;
            mbc1_mode_q <= 1'b0;
            b1_q        <= 5'd1;
            b2_q        <= 2'd0;
            rtc_latch_q <= 1'b0;
            bank_chg_q  <= 1'b0;
            wr_cnt_q    <= '0;
        end else begin
            latch_q     <= latch_d;
            wr_q        <= CART_WR;
            type_q      <= type_d;
            a_cap_q     <= a_cap_d;
            d_cap_q     <= d_cap_d;
            rom_bank_q  <= rom_bank_d;
            ram_bank_q  <= ram_bank_d;
            ram_en_q    <= ram_en_d;
            rtc_sel_q   <= rtc_sel_d;
            rtc_mode_q  <= rtc_mode_d;
            mbc1_mode_q <= mbc1_mode_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            rtc_latch_q <= rtc_latch_d;
            bank_chg_q  <= bank_chg_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    assign rom_bank  = rom_bank_q;
    assign ram_bank  = ram_bank_q;
    assign ram_en    = ram_en_q;
    assign rtc_sel   = rtc_sel_q;
    assign rtc_mode  = rtc_mode_q;
    assign mbc1_mode = mbc1_mode_q;
    assign rtc_latch = rtc_latch_q;
    assign bank_chg  = bank_chg_q;
    assign wr_cnt    = wr_cnt_q;

endmodule

// File: tb/tb_cart_mbc_snoop.sv
// Directed bench for cart_mbc_snoop: a default-width instance plus a 4-bit counter instance
// sharing the same bus, checked with immediate assertions against hand-computed values.
module tb_cart_mbc_snoop;

    logic        hclk = 1'b0;
    logic        gbreset = 1'b1;
    logic [2:0]  mbc_type = 3'd5;
    logic [15:0] CART_A = 16'h0000;
    logic        CART_WR = 1'b1;
    logic [7:0]  CART_DOUT = 8'h00;

    logic [8:0]  rom_bank, s_rom_bank;
    logic [3:0]  ram_bank, s_ram_bank;
    logic        ram_en, s_ram_en;
    logic [3:0]  rtc_sel, s_rtc_sel;
    logic        rtc_mode, s_rtc_mode;
    logic        mbc1_mode, s_mbc1_mode;
    logic        rtc_latch, s_rtc_latch;
    logic        bank_chg, s_bank_chg;
    logic [15:0] wr_cnt;
    logic [3:0]  s_wr_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int chg_cnt = 0;
    int latch_cnt = 0;

    always #5 hclk = ~hclk;

    cart_mbc_snoop #(.WCNT_W(16)) dut (
        .hclk(hclk), .gbreset(gbreset), .mbc_type(mbc_type), .CART_A(CART_A),
        .CART_WR(CART_WR), .CART_DOUT(CART_DOUT), .rom_bank(rom_bank), .ram_bank(ram_bank),
        .ram_en(ram_en), .rtc_sel(rtc_sel), .rtc_mode(rtc_mode), .mbc1_mode(mbc1_mode),
        .rtc_latch(rtc_latch), .bank_chg(bank_chg), .wr_cnt(wr_cnt)
    );

    cart_mbc_snoop #(.WCNT_W(4)) dut_sat (
        .hclk(hclk), .gbreset(gbreset), .mbc_type(mbc_type), .CART_A(CART_A),
        .CART_WR(CART_WR), .CART_DOUT(CART_DOUT), .rom_bank(s_rom_bank),
        .ram_bank(s_ram_bank), .ram_en(s_ram_en), .rtc_sel(s_rtc_sel),
        .rtc_mode(s_rtc_mode), .mbc1_mode(s_mbc1_mode), .rtc_latch(s_rtc_latch),
        .bank_chg(s_bank_chg), .wr_cnt(s_wr_cnt)
    );

    // Pulse counters: a pulse wider than one cycle is counted more than once.
    always @(posedge hclk) begin
        if (bank_chg) chg_cnt++;
        if (rtc_latch) latch_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge hclk);
        CART_A    = a;
        CART_DOUT = d;
        CART_WR   = 1'b0;
        @(negedge hclk);
        @(negedge hclk);
        CART_A    = 16'hFFFF;
        CART_DOUT = 8'hEE;
        @(negedge hclk);
        CART_WR   = 1'b1;
        @(negedge hclk);
        @(negedge hclk);
    endtask

    task automatic set_type(input logic [2:0] t);
        @(negedge hclk);
        mbc_type = t;
        repeat (2) @(negedge hclk);
    endtask

    initial begin
        int c0;
        repeat (2) @(negedge hclk);
        gbreset = 1'b0;
        repeat (2) @(negedge hclk);
        chk("rst_rom", 32'(rom_bank), 32'h1);
        chk("rst_ram", 32'(ram_bank), 32'h0);
        chk("rst_ram_en", 32'(ram_en), 32'h0);
        chk("rst_rtc_sel", 32'(rtc_sel), 32'h0);
        chk("rst_rtc_mode", 32'(rtc_mode), 32'h0);
        chk("rst_mbc1_mode", 32'(mbc1_mode), 32'h0);
        chk("rst_wr_cnt", 32'(wr_cnt), 32'h0);
        chk("rst_bank_chg", 32'(bank_chg), 32'h0);

        // MBC5 basic sequence
        chg_cnt = 0;
        wr(16'h0000, 8'h0A);
        wr(16'h2000, 8'h34);
        wr(16'h3000, 8'h01);
        wr(16'h4000, 8'h05);
        chk("mbc5_ram_en", 32'(ram_en), 32'h1);
        chk("mbc5_rom", 32'(rom_bank), 32'h134);
        chk("mbc5_ram", 32'(ram_bank), 32'h5);
        chk("mbc5_wr_cnt", 32'(wr_cnt), 32'd4);
        chk("mbc5_chg_pulses", 32'(chg_cnt), 32'd3);
        chk("sat_cnt_4", 32'(s_wr_cnt), 32'd4);

        // Writes outside the ROM region are invisible
        wr(16'hA000, 8'h55);
        wr(16'hC000, 8'h12);
        chk("ign_rom", 32'(rom_bank), 32'h134);
        chk("ign_ram", 32'(ram_bank), 32'h5);
        chk("ign_wr_cnt", 32'(wr_cnt), 32'd4);
        chk("ign_chg", 32'(chg_cnt), 32'd3);

        // Same-value rewrite counts but does not pulse
        wr(16'h2000, 8'h34);
        chk("rewr_chg", 32'(chg_cnt), 32'd3);
        chk("rewr_wr_cnt", 32'(wr_cnt), 32'd5);

        // MBC5 bank 0 is legal
        wr(16'h2000, 8'h00);
        wr(16'h3000, 8'h00);
        chk("mbc5_bank0", 32'(rom_bank), 32'h000);

        wr(16'h2000, 8'hFF);
        wr(16'h3000, 8'h01);
        chk("mbc5_rom_1ff", 32'(rom_bank), 32'h1FF);
        chk("mbc5_wr_cnt9", 32'(wr_cnt), 32'd9);

        // Type change: bank state resets, counter kept
        set_type(3'd1);
        chk("tchg_rom", 32'(rom_bank), 32'h1);
        chk("tchg_ram", 32'(ram_bank), 32'h0);
        chk("tchg_ram_en", 32'(ram_en), 32'h0);
        chk("tchg_wr_cnt", 32'(wr_cnt), 32'd9);

        // MBC1
        wr(16'h2000, 8'h00);
        chk("mbc1_b1_zero", 32'(rom_bank), 32'h1);
        wr(16'h4000, 8'h02);
        wr(16'h6000, 8'h01);
        chk("mbc1_rom", 32'(rom_bank), 32'h41);
        chk("mbc1_ram", 32'(ram_bank), 32'h2);
        chk("mbc1_mode", 32'(mbc1_mode), 32'h1);
        chk("mbc1_wr_cnt", 32'(wr_cnt), 32'd12);

        // MBC3 latch sequences and RTC select
        set_type(3'd3);
        latch_cnt = 0;
        wr(16'h6000, 8'h00);
        wr(16'h6000, 8'h01);
        chk("mbc3_latch_one", 32'(latch_cnt), 32'd1);
        wr(16'h6000, 8'h00);
        wr(16'h6000, 8'h02);
        wr(16'h6000, 8'h01);
        chk("mbc3_latch_broken", 32'(latch_cnt), 32'd1);
        wr(16'h4000, 8'h0A);
        chk("mbc3_rtc_mode", 32'(rtc_mode), 32'h1);
        chk("mbc3_rtc_sel", 32'(rtc_sel), 32'hA);
        wr(16'h2000, 8'h85);
        chk("mbc3_rom", 32'(rom_bank), 32'h5);
        wr(16'h4000, 8'h03);
        chk("mbc3_ram", 32'(ram_bank), 32'h3);
        chk("mbc3_rtc_off", 32'(rtc_sel), 32'h0);
        chk("mbc3_wr_cnt", 32'(wr_cnt), 32'd20);
        chk("sat_cnt_15", 32'(s_wr_cnt), 32'd15);

        // Unknown mapper ignores everything
        set_type(3'd2);
        c0 = chg_cnt;
        wr(16'h2000, 8'h07);
        chk("none_rom", 32'(rom_bank), 32'h1);
        chk("none_wr_cnt", 32'(wr_cnt), 32'd20);
        chk("none_chg", 32'(chg_cnt), 32'(c0));

        // Async reset in the middle of a strobe discards the capture
        set_type(3'd3);
        @(negedge hclk);
        CART_A    = 16'h2000;
        CART_DOUT = 8'h07;
        CART_WR   = 1'b0;
        @(negedge hclk);
        @(negedge hclk);
        #2 gbreset = 1'b1;
        #1;
        chk("arst_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("arst_rom", 32'(rom_bank), 32'h1);
        @(negedge hclk);
        CART_WR = 1'b1;
        @(negedge hclk);
        gbreset = 1'b0;
        repeat (3) @(negedge hclk);
        chk("arst_no_commit_rom", 32'(rom_bank), 32'h1);
        chk("arst_no_commit_cnt", 32'(wr_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
